// File: rtl/dsram_store_buffer_if.sv
// dsram_store_buffer_if
//  Bundles the store request, load probe and dsram write-port signals of the
//  store buffer.
//  master : store/load source side (drives requests, observes write port)
//  slave  : the store buffer itself
//  Signals:
//   st_valid/st_ready/st_index/st_way/st_offset/st_size/st_data : store request
//   arr_busy                                                   : array read, inhibits drain
//   ld_valid/ld_index/ld_way/ld_conflict                       : load hazard probe
//   wr_en/wr_aq/wr_be/wr_wd                                    : dsram write port
//   sb_count                                                   : valid entry count
interface dsram_store_buffer_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAY_BITS   = 2,
  parameter int DEPTH      = 4
);
  localparam int NWAYS = 2 ** WAY_BITS;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_index;
  logic [WAY_BITS-1:0]   st_way;
  logic [4:0]            st_offset;
  logic [1:0]            st_size;
  logic [63:0]           st_data;
  logic                  arr_busy;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_index;
  logic [WAY_BITS-1:0]   ld_way;
  logic                  ld_conflict;
  logic [NWAYS-1:0]      wr_en;
  logic [ADDR_WIDTH-1:0] wr_aq;
  logic [31:0]           wr_be;
  logic [255:0]          wr_wd;
  logic [CNT_W-1:0]      sb_count;

  modport master (
    output st_valid, st_index, st_way, st_offset, st_size, st_data,
    output arr_busy, ld_valid, ld_index, ld_way,
    input  st_ready, ld_conflict, wr_en, wr_aq, wr_be, wr_wd, sb_count
  );

  modport slave (
    input  st_valid, st_index, st_way, st_offset, st_size, st_data,
    input  arr_busy, ld_valid, ld_index, ld_way,
    output st_ready, ld_conflict, wr_en, wr_aq, wr_be, wr_wd, sb_count
  );
endinterface

// File: rtl/dsram_store_buffer.sv
// dsram_store_buffer
//  Store staging buffer in front of the per-way data SRAMs. Stores of 1/2/4/8
//  bytes are steered into byte lanes of a 256-bit line, merged with the
//  youngest entry when they hit the same line, and held in a DEPTH-entry FIFO.
//  The head drains to the dsram write port in cycles with no array read.
//  Loads are probed against pending and in-flight stores for RAW hazards.
//  Ports:
//   clk     : clock, all state on posedge
//   reset_n : synchronous active-low reset
//   bus     : dsram_store_buffer_if.slave (store, load probe, write port, count)
module dsram_store_buffer #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAY_BITS   = 2,
  parameter int DEPTH      = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  dsram_store_buffer_if.slave  bus
);
  localparam int NWAYS = 2 ** WAY_BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; vld_q marks live entries for the hazard probe.
  logic [ADDR_WIDTH-1:0] idx_q [DEPTH];
  logic [WAY_BITS-1:0]   way_q [DEPTH];
  logic [31:0]           be_q  [DEPTH];
  logic [255:0]          wd_q  [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [NWAYS-1:0]      wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_aq_q;
  logic [31:0]           wr_be_q;
  logic [255:0]          wr_wd_q;

  logic [4:0]            st_off_s;
  logic [31:0]           st_be_base_s, st_be_s;
  logic [63:0]           st_data_s;
  logic [255:0]          st_wd_s, st_bmask_s;
  logic [PTR_W-1:0]      youngest_s;
  logic                  st_ready_s, accept_s, merge_s, alloc_s, merge_en_s, drain_fire_s;
  logic                  ld_hit_s;

  // Lane steering: force natural alignment and place data/byte enables.
  always_comb begin
    st_off_s     = 5'd0;
    st_be_base_s = 32'd0;
    st_data_s    = 64'd0;
    case (bus.st_size)
      2'd0: begin
        st_off_s     = bus.st_offset;
        st_be_base_s = 32'h0000_0001;
        st_data_s    = {56'd0, bus.st_data[7:0]};
      end
      2'd1: begin
        st_off_s     = {bus.st_offset[4:1], 1'b0};
        st_be_base_s = 32'h0000_0003;
        st_data_s    = {48'd0, bus.st_data[15:0]};
      end
      2'd2: begin
        st_off_s     = {bus.st_offset[4:2], 2'b00};
        st_be_base_s = 32'h0000_000F;
        st_data_s    = {32'd0, bus.st_data[31:0]};
      end
      default: begin
        st_off_s     = {bus.st_offset[4:3], 3'b000};
        st_be_base_s = 32'h0000_00FF;
        st_data_s    = bus.st_data;
      end
    endcase
    st_be_s = st_be_base_s << st_off_s;
    st_wd_s = {192'd0, st_data_s} << {st_off_s, 3'b000};
    for (int b = 0; b < 32; b++) begin
      st_bmask_s[8*b +: 8] = {8{st_be_s[b]}};
    end
  end

  // Handshake, merge decision and occupancy update.
  always_comb begin
    st_ready_s   = (count_q < CNT_W'(DEPTH)) & reset_n;
    accept_s     = bus.st_valid & st_ready_s;
    drain_fire_s = (count_q != CNT_W'(0)) & ~bus.arr_busy;
    youngest_s   = tail_q - PTR_W'(1);
    // Never merge into the head while it is being written out this edge.
    merge_s      = (count_q != CNT_W'(0)) &&
                   (idx_q[youngest_s] == bus.st_index) &&
                   (way_q[youngest_s] == bus.st_way) &&
                   !(drain_fire_s && (youngest_s == head_q));
    alloc_s      = accept_s & ~merge_s;
    merge_en_s   = accept_s & merge_s;
    case ({alloc_s, drain_fire_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // RAW hazard probe against live entries and the write on the port.
  always_comb begin
    ld_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (idx_q[i] == bus.ld_index) && (way_q[i] == bus.ld_way)) begin
        ld_hit_s = 1'b1;
      end else begin
        ld_hit_s = ld_hit_s;
      end
    end
    if (wr_en_q[bus.ld_way] && (wr_aq_q == bus.ld_index)) begin
      ld_hit_s = 1'b1;
    end else begin
      ld_hit_s = ld_hit_s;
    end
  end

  // FIFO state, merge writes and the registered dsram write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      wr_en_q <= '0;
      wr_aq_q <= '0;
      wr_be_q <= 32'd0;
      wr_wd_q <= 256'd0;
    end else begin
      if (drain_fire_s) begin
        wr_en_q       <= NWAYS'(1) << way_q[head_q];
        wr_aq_q       <= idx_q[head_q];
        wr_be_q       <= be_q[head_q];
        wr_wd_q       <= wd_q[head_q];
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end else begin
        wr_en_q <= '0;
      end
      if (alloc_s) begin
        idx_q[tail_q] <= bus.st_index;
        way_q[tail_q] <= bus.st_way;
        be_q[tail_q]  <= st_be_s;
        wd_q[tail_q]  <= st_wd_s;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end else if (merge_en_s) begin
        be_q[youngest_s] <= be_q[youngest_s] | st_be_s;
        wd_q[youngest_s] <= (wd_q[youngest_s] & ~st_bmask_s) | st_wd_s;
      end
      count_q <= count_d;
    end
  end

  assign bus.st_ready    = st_ready_s;
  assign bus.ld_conflict = bus.ld_valid & ld_hit_s & reset_n;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_aq       = wr_aq_q;
  assign bus.wr_be       = wr_be_q;
  assign bus.wr_wd       = wr_wd_q;
  assign bus.sb_count    = count_q;
endmodule

// File: tb/tb_dsram_store_buffer.sv
module tb_dsram_store_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dsram_store_buffer_if #(.ADDR_WIDTH(13), .WAY_BITS(2), .DEPTH(4)) sb_if ();

  dsram_store_buffer #(.ADDR_WIDTH(13), .WAY_BITS(2), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sb_if.slave)
  );

  typedef struct packed {
    logic [3:0]   en;
    logic [12:0]  aq;
    logic [31:0]  be;
    logic [255:0] wd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_pass = 0;
  int  n_total = 0;
  logic rdy;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic push_exp(input logic [3:0] en, input logic [12:0] aq,
                          input logic [31:0] be, input logic [255:0] wd);
    wr_t e;
    e.en = en; e.aq = aq; e.be = be; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic do_store(input logic [12:0] idx, input logic [1:0] way, input logic [4:0] off,
                          input logic [1:0] sz, input logic [63:0] d, output logic ready);
    @(negedge clk);
    sb_if.st_valid  = 1'b1;
    sb_if.st_index  = idx;
    sb_if.st_way    = way;
    sb_if.st_offset = off;
    sb_if.st_size   = sz;
    sb_if.st_data   = d;
    #1 ready = sb_if.st_ready;
    @(posedge clk);
    #1 sb_if.st_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write presented on the port is compared with the queue head.
  always @(negedge clk) begin
    if (sb_if.wr_en !== 4'd0) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write got en=%0h aq=%0h be=%0h", sb_if.wr_en, sb_if.wr_aq, sb_if.wr_be);
      end else begin
        mon_e = exp_q.pop_front();
        if (sb_if.wr_en === mon_e.en && sb_if.wr_aq === mon_e.aq &&
            sb_if.wr_be === mon_e.be && sb_if.wr_wd === mon_e.wd) begin
          n_pass++;
        end else begin
          $display("FAIL dsram_write got en=%0h aq=%0h be=%0h wd=%0h exp en=%0h aq=%0h be=%0h wd=%0h",
                   sb_if.wr_en, sb_if.wr_aq, sb_if.wr_be, sb_if.wr_wd,
                   mon_e.en, mon_e.aq, mon_e.be, mon_e.wd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    sb_if.st_valid = 1'b0; sb_if.st_index = 13'd0; sb_if.st_way = 2'd0;
    sb_if.st_offset = 5'd0; sb_if.st_size = 2'd0; sb_if.st_data = 64'd0;
    sb_if.arr_busy = 1'b0; sb_if.ld_valid = 1'b0; sb_if.ld_index = 13'd0; sb_if.ld_way = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("st_ready_in_reset", 256'(sb_if.st_ready), 256'(1'b0));
    reset_n = 1'b1;
    #1;
    check("rst_st_ready", 256'(sb_if.st_ready), 256'(1'b1));
    check("rst_count", 256'(sb_if.sb_count), 256'(3'd0));
    check("rst_wr_en", 256'(sb_if.wr_en), 256'(4'd0));
    check("rst_wr_aq", 256'(sb_if.wr_aq), 256'(13'd0));
    check("rst_wr_be", 256'(sb_if.wr_be), 256'(32'd0));
    check("rst_wr_wd", sb_if.wr_wd, 256'd0);

    // 1: single 8-byte store, latency
    push_exp(4'b0100, 13'd5, 32'h0000FF00, {128'd0, 64'h1122334455667788, 64'd0});
    do_store(13'd5, 2'd2, 5'd8, 2'd3, 64'h1122334455667788, rdy);
    check("t1_ready", 256'(rdy), 256'(1'b1));
    @(negedge clk);
    check("t1_wr_en_before", 256'(sb_if.wr_en), 256'(4'd0));
    check("t1_count", 256'(sb_if.sb_count), 256'(3'd1));
    @(negedge clk);
    check("t1_wr_en_latency", 256'(sb_if.wr_en), 256'(4'b0100));
    check("t1_count_after", 256'(sb_if.sb_count), 256'(3'd0));
    repeat (2) @(negedge clk);

    // 2: merge of two stores to the same line while busy
    sb_if.arr_busy = 1'b1;
    push_exp(4'b0001, 13'd7, 32'h0000000F, {224'd0, 32'hBBBBAAAA});
    do_store(13'd7, 2'd0, 5'd0, 2'd2, 64'hAAAAAAAA, rdy);
    do_store(13'd7, 2'd0, 5'd2, 2'd1, 64'hBBBB, rdy);
    @(negedge clk);
    check("t2_count_merged", 256'(sb_if.sb_count), 256'(3'd1));
    check("t2_no_write_busy", 256'(sb_if.wr_en), 256'(4'd0));
    sb_if.arr_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_count_drained", 256'(sb_if.sb_count), 256'(3'd0));

    // 3: fill to DEPTH, fifth store refused, ordered back-to-back drain
    sb_if.arr_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(4'b0001, 13'd20 + 13'(i), 32'h1, 256'(8'h10 + 8'(i)));
      do_store(13'd20 + 13'(i), 2'd0, 5'd0, 2'd0, 64'(8'h10 + 8'(i)), rdy);
      check("t3_ready", 256'(rdy), 256'(1'b1));
    end
    do_store(13'd24, 2'd0, 5'd0, 2'd0, 64'h99, rdy);
    check("t3_ready_full", 256'(rdy), 256'(1'b0));
    @(negedge clk);
    check("t3_count_full", 256'(sb_if.sb_count), 256'(3'd4));
    sb_if.arr_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_drain_consec", 256'(sb_if.wr_en), 256'(4'b0001));
    end
    @(negedge clk);
    check("t3_drain_done", 256'(sb_if.wr_en), 256'(4'd0));
    check("t3_count_empty", 256'(sb_if.sb_count), 256'(3'd0));

    // 4: load hazard probe
    sb_if.arr_busy = 1'b1;
    @(negedge clk);
    sb_if.st_valid = 1'b1; sb_if.st_index = 13'd9; sb_if.st_way = 2'd1;
    sb_if.st_offset = 5'd0; sb_if.st_size = 2'd0; sb_if.st_data = 64'h5A;
    sb_if.ld_valid = 1'b1; sb_if.ld_index = 13'd9; sb_if.ld_way = 2'd1;
    #1 check("t4_same_cycle_excluded", 256'(sb_if.ld_conflict), 256'(1'b0));
    push_exp(4'b0010, 13'd9, 32'h1, 256'(8'h5A));
    @(posedge clk);
    #1 sb_if.st_valid = 1'b0;
    #1 check("t4_ld_hit", 256'(sb_if.ld_conflict), 256'(1'b1));
    sb_if.ld_way = 2'd3;
    #1 check("t4_ld_other_way", 256'(sb_if.ld_conflict), 256'(1'b0));
    sb_if.ld_way = 2'd1;
    @(negedge clk);
    sb_if.arr_busy = 1'b0;
    @(negedge clk);
    check("t4_ld_inflight", 256'(sb_if.ld_conflict), 256'(1'b1));
    @(negedge clk);
    check("t4_ld_after_drain", 256'(sb_if.ld_conflict), 256'(1'b0));
    sb_if.ld_valid = 1'b0;

    // 5: misaligned store forced to natural alignment; top-of-line 8-byte store
    push_exp(4'b1000, 13'd3, 32'h0000000F, {224'd0, 32'hDEADBEEF});
    do_store(13'd3, 2'd3, 5'd3, 2'd2, 64'hDEADBEEF, rdy);
    push_exp(4'b0001, 13'd4, 32'hFF000000, {64'hCAFEF00D12345678, 192'd0});
    do_store(13'd4, 2'd0, 5'd31, 2'd3, 64'hCAFEF00D12345678, rdy);
    repeat (3) @(negedge clk);

    // 7: store to the line whose head is popping must allocate, not merge
    push_exp(4'b0010, 13'd11, 32'h1, 256'(8'h11));
    push_exp(4'b0010, 13'd11, 32'h2, 256'(16'h2200));
    do_store(13'd11, 2'd1, 5'd0, 2'd0, 64'h11, rdy);
    do_store(13'd11, 2'd1, 5'd1, 2'd0, 64'h22, rdy);
    repeat (4) @(negedge clk);

    // 6: reset with a full buffer discards everything
    sb_if.arr_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(13'd30 + 13'(i), 2'd0, 5'd0, 2'd0, 64'h77, rdy);
    end
    @(negedge clk);
    check("t6_count_full", 256'(sb_if.sb_count), 256'(3'd4));
    reset_n = 1'b0;
    sb_if.ld_valid = 1'b1; sb_if.ld_index = 13'd30; sb_if.ld_way = 2'd0;
    #1;
    check("t6_ready_in_reset", 256'(sb_if.st_ready), 256'(1'b0));
    check("t6_ld_in_reset", 256'(sb_if.ld_conflict), 256'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    sb_if.ld_valid = 1'b0;
    check("t6_count_reset", 256'(sb_if.sb_count), 256'(3'd0));
    check("t6_wr_en_reset", 256'(sb_if.wr_en), 256'(4'd0));
    sb_if.arr_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_count_stays", 256'(sb_if.sb_count), 256'(3'd0));

    check("exp_queue_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
